// File: rtl/inta_sequencer.sv
// CPU-side 8259 acknowledge sequencer: two INTA_N pulses, vector capture, core handoff, EOI write.
// Define INTA_NESTING_EN to allow a higher-priority INT to be acknowledged while a handler runs.
module inta_sequencer #(
  parameter int INTA_LOW  = 2,
  parameter int INTA_GAP  = 1,
  parameter int WR_LOW    = 2,
  parameter int MAX_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INT,
  input  logic       IE,
  input  logic       AEOI,
  input  logic [7:0] DATA_IN,
  input  logic       VECTOR_TAKEN,
  input  logic       HANDLER_DONE,
  output logic       INTA_N,
  output logic       WR_N,
  output logic       A0,
  output logic [7:0] DATA_OUT,
  output logic [7:0] VECTOR,
  output logic       VECTOR_VALID,
  output logic       BUSY,
  output logic [3:0] NEST_DEPTH,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK1    = 3'd1,
    GAP     = 3'd2,
    ACK2    = 3'd3,
    PRESENT = 3'd4,
    HANDLER = 3'd5,
    EOI     = 3'd6
  } state_t;

  localparam logic [3:0] LOW_LOAD  = 4'(INTA_LOW - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(INTA_GAP - 1);
  localparam logic [3:0] WR_LOAD   = 4'(WR_LOW - 1);
  localparam logic [3:0] DEPTH_MAX = 4'(MAX_DEPTH);
  localparam logic [7:0] OCW2_EOI  = 8'h20;

  state_t     state;
  logic [3:0] cnt;

  assign state_dbg = state;

  // Core handshake: VECTOR_VALID stays high with VECTOR frozen until the core
  // pulses VECTOR_TAKEN for one clock; the transfer completes on that edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      INTA_N       <= 1'b1;
      WR_N         <= 1'b1;
      A0           <= 1'b1;
      DATA_OUT     <= 8'h00;
      VECTOR       <= 8'h00;
      VECTOR_VALID <= 1'b0;
      BUSY         <= 1'b0;
      NEST_DEPTH   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (INT && IE) begin
            state  <= ACK1;
            INTA_N <= 1'b0;
            BUSY   <= 1'b1;
            cnt    <= LOW_LOAD;
          end
        end

        ACK1: begin
          if (cnt == 4'd0) begin
            state  <= GAP;
            INTA_N <= 1'b1;
            cnt    <= GAP_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        GAP: begin
          if (cnt == 4'd0) begin
            state  <= ACK2;
            INTA_N <= 1'b0;
            cnt    <= LOW_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        // The PIC drives the vector during the second pulse; take it as the pulse ends.
        ACK2: begin
          if (cnt == 4'd0) begin
            state        <= PRESENT;
            INTA_N       <= 1'b1;
            VECTOR       <= DATA_IN;
            VECTOR_VALID <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        PRESENT: begin
          if (VECTOR_TAKEN) begin
            state        <= HANDLER;
            VECTOR_VALID <= 1'b0;
            NEST_DEPTH   <= (NEST_DEPTH == DEPTH_MAX) ? NEST_DEPTH : NEST_DEPTH + 4'd1;
          end
        end

        HANDLER: begin
          if (HANDLER_DONE) begin
            if (AEOI) begin
              NEST_DEPTH <= NEST_DEPTH - 4'd1;
              if (NEST_DEPTH <= 4'd1) begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end
            end else begin
              state    <= EOI;
              WR_N     <= 1'b0;
              A0       <= 1'b0;
              DATA_OUT <= OCW2_EOI;
              cnt      <= WR_LOAD;
            end
          end
`ifdef INTA_NESTING_EN
          else if (INT && IE && (NEST_DEPTH < DEPTH_MAX)) begin
            state  <= ACK1;
            INTA_N <= 1'b0;
            cnt    <= LOW_LOAD;
          end
`endif
        end

        EOI: begin
          if (cnt == 4'd0) begin
            WR_N       <= 1'b1;
            A0         <= 1'b1;
            DATA_OUT   <= 8'h00;
            NEST_DEPTH <= NEST_DEPTH - 4'd1;
            if (NEST_DEPTH <= 4'd1) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= HANDLER;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          state  <= IDLE;
          INTA_N <= 1'b1;
          WR_N   <= 1'b1;
          A0     <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed timeline runs plus randomized transactions,
// with a negedge monitor checking presented vectors, pulse shapes, EOI writes and depth.
module tb_inta_sequencer;

  localparam int INTA_LOW  = 2;
  localparam int INTA_GAP  = 1;
  localparam int WR_LOW    = 2;
  localparam int MAX_DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INT = 1'b0;
  logic       IE = 1'b0;
  logic       AEOI = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       VECTOR_TAKEN = 1'b0;
  logic       HANDLER_DONE = 1'b0;
  logic       INTA_N, WR_N, A0, VECTOR_VALID, BUSY;
  logic [7:0] DATA_OUT, VECTOR;
  logic [3:0] NEST_DEPTH;
  logic [2:0] state_dbg;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_eoi_q[$];
  logic [3:0] exp_depth_q[$];

  inta_sequencer #(
    .INTA_LOW(INTA_LOW), .INTA_GAP(INTA_GAP), .WR_LOW(WR_LOW), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .INT(INT), .IE(IE), .AEOI(AEOI), .DATA_IN(DATA_IN),
    .VECTOR_TAKEN(VECTOR_TAKEN), .HANDLER_DONE(HANDLER_DONE),
    .INTA_N(INTA_N), .WR_N(WR_N), .A0(A0), .DATA_OUT(DATA_OUT), .VECTOR(VECTOR),
    .VECTOR_VALID(VECTOR_VALID), .BUSY(BUSY), .NEST_DEPTH(NEST_DEPTH), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         prev_inta = 1'b1;
  bit         prev_wr = 1'b1;
  bit         prev_vv = 1'b0;
  logic [3:0] prev_depth = 4'd0;
  int         inta_low_run = 0;
  int         inta_high_run = 0;
  int         wr_low_run = 0;
  int         pulse_idx = 0;
  logic [7:0] cur_vec = 8'h00;
  logic [7:0] eoi_byte = 8'h00;

  always @(negedge CLK) begin
    if (RST) begin
      prev_inta = 1'b1; prev_wr = 1'b1; prev_vv = 1'b0; prev_depth = 4'd0;
      inta_low_run = 0; inta_high_run = 0; wr_low_run = 0; pulse_idx = 0;
    end else begin
      check("inta_wr_overlap", int'(!INTA_N && !WR_N), 0);

      if (!INTA_N) begin
        if (prev_inta && pulse_idx == 1) check("inta_gap_width", inta_high_run, INTA_GAP);
        inta_low_run++;
      end else begin
        if (!prev_inta) begin
          check("inta_low_width", inta_low_run, INTA_LOW);
          pulse_idx = 1 - pulse_idx;
          inta_low_run = 0;
          inta_high_run = 0;
        end
        inta_high_run++;
      end

      if (VECTOR_VALID && !prev_vv) begin
        if (exp_q.size() == 0) check("vector_unexpected", 1, 0);
        else cur_vec = exp_q.pop_front();
      end
      if (VECTOR_VALID) check("vector_value", VECTOR, cur_vec);

      if (!WR_N) begin
        if (prev_wr) begin
          wr_low_run = 0;
          if (exp_eoi_q.size() == 0) check("eoi_unexpected", 1, 0);
          else eoi_byte = exp_eoi_q.pop_front();
        end
        wr_low_run++;
        check("eoi_data", DATA_OUT, eoi_byte);
        check("eoi_a0", A0, 0);
      end else begin
        if (!prev_wr) check("eoi_width", wr_low_run, WR_LOW);
        check("idle_data_out", DATA_OUT, 0);
        check("idle_a0", A0, 1);
      end

      if (NEST_DEPTH != prev_depth) begin
        if (exp_depth_q.size() == 0) check("depth_unexpected", NEST_DEPTH, prev_depth);
        else check("nest_depth", NEST_DEPTH, exp_depth_q.pop_front());
      end

      prev_inta = INTA_N; prev_wr = WR_N; prev_vv = VECTOR_VALID; prev_depth = NEST_DEPTH;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  // sel: 0 INTA_N, 1 VECTOR_VALID, 2 BUSY, 3 WR_N
  task automatic wait_for(input string name, input int sel, input bit level, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK);
      case (sel)
        0: hit = (INTA_N == level);
        1: hit = (VECTOR_VALID == level);
        2: hit = (BUSY == level);
        default: hit = (WR_N == level);
      endcase
    end
    check({name, "_timeout"}, int'(hit), 1);
  endtask

  task automatic pulse_taken();
    step(); VECTOR_TAKEN = 1'b1;
    step(); VECTOR_TAKEN = 1'b0;
  endtask

  task automatic pulse_done(input bit aeoi);
    step(); HANDLER_DONE = 1'b1; AEOI = aeoi;
    step(); HANDLER_DONE = 1'b0; AEOI = 1'($urandom_range(0, 1));
  endtask

  // Cycle-exact run; n counts edges after the one where INT/IE are first presented.
  task automatic run_directed(input logic [7:0] data, input bit aeoi, input int drop);
    int vstart = 2 * INTA_LOW + INTA_GAP + 1;
    int tk = vstart + 2;
    int hd = tk + 2;
    int fin = aeoi ? hd + 1 : hd + WR_LOW + 1;
    bit e_inta, e_vv, e_wr, e_busy;
    int e_depth;
    exp_q.push_back(data);
    step(); DATA_IN = data; AEOI = aeoi; INT = 1'b1; IE = 1'b1;
    for (int n = 1; n <= fin + 1; n++) begin
      step();
      if (n == drop) INT = 1'b0;
      VECTOR_TAKEN = (n == tk);
      HANDLER_DONE = (n == hd);
      if (n == tk) exp_depth_q.push_back(4'd1);
      if (n == hd) begin
        exp_depth_q.push_back(4'd0);
        if (!aeoi) exp_eoi_q.push_back(8'h20);
      end
      @(negedge CLK);
      e_inta  = !((n >= 1 && n <= INTA_LOW) ||
                  (n >= INTA_LOW + INTA_GAP + 1 && n <= 2 * INTA_LOW + INTA_GAP));
      e_vv    = (n >= vstart && n <= tk);
      e_wr    = !(!aeoi && n >= hd + 1 && n <= hd + WR_LOW);
      e_busy  = (n >= 1 && n < fin);
      e_depth = (n > tk && n < fin) ? 1 : 0;
      check($sformatf("dir_inta_n[%0d]", n), INTA_N, e_inta);
      check($sformatf("dir_vector_valid[%0d]", n), VECTOR_VALID, e_vv);
      check($sformatf("dir_wr_n[%0d]", n), WR_N, e_wr);
      check($sformatf("dir_busy[%0d]", n), BUSY, e_busy);
      check($sformatf("dir_depth[%0d]", n), NEST_DEPTH, e_depth);
      if (n == vstart) check("dir_vector", VECTOR, data);
    end
    INT = 1'b0;
  endtask

  task automatic run_random();
    logic [7:0] data = 8'($urandom);
    bit aeoi = 1'($urandom_range(0, 1));
    int drop_at = $urandom_range(0, 2 * INTA_LOW + INTA_GAP - 1);
    exp_q.push_back(data);
    step(); DATA_IN = data; INT = 1'b1; IE = 1'b1;
    wait_for("ack_start", 0, 1'b0, 4);
    repeat (drop_at) step();
    if ($urandom_range(0, 1) == 1) INT = 1'b0; else IE = 1'b0;
    wait_for("present", 1, 1'b1, 40);
    INT = 1'b0;
    repeat ($urandom_range(0, 3)) step();
    if ($urandom_range(0, 3) == 0) pulse_done(1'($urandom_range(0, 1)));
    exp_depth_q.push_back(4'd1);
    pulse_taken();
    if ($urandom_range(0, 3) == 0) pulse_taken();
    repeat ($urandom_range(0, 5)) step();
    exp_depth_q.push_back(4'd0);
    if (!aeoi) exp_eoi_q.push_back(8'h20);
    pulse_done(aeoi);
    wait_for("return_idle", 2, 1'b0, 20);
    repeat ($urandom_range(0, 3)) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lows, busy_hi, wr_lows;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_inta_n", INTA_N, 1);
    check("rst_wr_n", WR_N, 1);
    check("rst_a0", A0, 1);
    check("rst_data_out", DATA_OUT, 0);
    check("rst_vector", VECTOR, 0);
    check("rst_vector_valid", VECTOR_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_depth", NEST_DEPTH, 0);
    step(); RST = 1'b0;
    repeat (2) step();

    run_directed(8'h0B, 1'b0, 2 * INTA_LOW + INTA_GAP + 1);
    repeat (2) step();
    run_directed(8'h0F, 1'b1, INTA_LOW + 1);
    repeat (2) step();

    // INT without IE must never start a sequence
    INT = 1'b1; IE = 1'b0; lows = 0; busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!INTA_N) lows++;
      if (BUSY) busy_hi++;
    end
    check("ie_off_inta_low_cycles", lows, 0);
    check("ie_off_busy_cycles", busy_hi, 0);
    step(); INT = 1'b0;
    repeat (2) step();

    // reset during the second pulse abandons everything
    step(); INT = 1'b1; IE = 1'b1; DATA_IN = 8'h55;
    repeat (2 * INTA_LOW + INTA_GAP - 1) step();
    check("rst_mid_ack2_inta_low", INTA_N, 0);
    RST = 1'b1; INT = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("rst_mid_inta_n", INTA_N, 1);
    check("rst_mid_vector_valid", VECTOR_VALID, 0);
    check("rst_mid_depth", NEST_DEPTH, 0);
    check("rst_mid_busy", BUSY, 0);
    step(); RST = 1'b0;
    wr_lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (!WR_N) wr_lows++;
    end
    check("rst_mid_no_eoi", wr_lows, 0);

`ifdef INTA_NESTING_EN
    exp_q.push_back(8'h21);
    step(); DATA_IN = 8'h21; INT = 1'b1; IE = 1'b1;
    wait_for("nest1_present", 1, 1'b1, 20);
    INT = 1'b0;
    exp_depth_q.push_back(4'd1);
    pulse_taken();
    repeat (2) step();
    exp_q.push_back(8'h22);
    DATA_IN = 8'h22; INT = 1'b1;
    wait_for("nest2_ack", 0, 1'b0, 4);
    wait_for("nest2_present", 1, 1'b1, 20);
    INT = 1'b0;
    exp_depth_q.push_back(4'd2);
    pulse_taken();
    repeat (2) step();
    exp_depth_q.push_back(4'd1);
    exp_eoi_q.push_back(8'h20);
    pulse_done(1'b0);
    wait_for("nest_eoi1_start", 3, 1'b0, 5);
    wait_for("nest_eoi1_end", 3, 1'b1, 10);
    @(negedge CLK);
    check("nest_busy_after_eoi1", BUSY, 1);
    repeat (2) step();
    exp_depth_q.push_back(4'd0);
    exp_eoi_q.push_back(8'h20);
    pulse_done(1'b0);
    wait_for("nest_idle", 2, 1'b0, 20);
`else
    // INT during a handler is ignored when nesting is not built in
    exp_q.push_back(8'h33);
    step(); DATA_IN = 8'h33; INT = 1'b1; IE = 1'b1;
    wait_for("nonest_present", 1, 1'b1, 20);
    INT = 1'b0;
    exp_depth_q.push_back(4'd1);
    pulse_taken();
    INT = 1'b1; lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!INTA_N) lows++;
    end
    check("nonest_inta_low_cycles", lows, 0);
    step(); INT = 1'b0;
    exp_depth_q.push_back(4'd0);
    pulse_done(1'b1);
    wait_for("nonest_idle", 2, 1'b0, 20);
`endif

    for (int t = 0; t < 40; t++) run_random();

    repeat (4) step();
    check("vector_queue_drained", exp_q.size(), 0);
    check("eoi_queue_drained", exp_eoi_q.size(), 0);
    check("depth_queue_drained", exp_depth_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
